// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-2 Booth multiplier.
// Holds the controller state encoding and the iteration-counter width helper.
package booth_pkg;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH (loaded on start), hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// booth_addsub: WIDTH-bit two's-complement adder/subtractor for the A +/- M step.
// The carry out is discarded; the caller sign-extends M so no overflow occurs.
module booth_addsub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  // Single add/subtract, result wraps modulo 2^WIDTH.
  always_comb begin
    sum = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth multiplier, one iteration per clock.
// Optional feature: define BOOTH_ABORT_EN to add the abort input, which cancels
// a multiply in progress without producing done or touching product.
//
// Handshake: start is a request qualified by ready. A start seen at a rising
// edge while ready=1 is accepted and the operands are captured on that edge;
// start while ready=0 (RUN) is ignored. done pulses for exactly one cycle when
// product becomes valid; product then holds until the next accepted start
// completes. ready is high in IDLE and DONE, so a start held through DONE is
// accepted back-to-back with no idle cycle.
module booth_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef BOOTH_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     addsub_sum;
  logic [WIDTH:0]     a_sel;
  logic               abort_in;

`ifdef BOOTH_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // A - M when the Booth pair is 10, A + M when it is 01.
  booth_addsub #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .a   (a_q),
    .b   (m_q),
    .sub (q_q[0]),
    .sum (addsub_sum)
  );

  // Pick the Booth-recoded partial result: add, subtract or pass A through.
  always_comb begin
    a_sel = a_q;
    case ({q_q[0], q1_q})
      2'b01, 2'b10: a_sel = addsub_sum;
      default:      a_sel = a_q;
    endcase
  end

  // Next-state and datapath update: load on accepted start, iterate in RUN.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = '0;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          q_d     = multiplier;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
        end
      end
      RUN: begin
        if (abort_in) begin
          // Cancelled: drop the operation, keep the previous product.
          state_d = IDLE;
        end else begin
          // Arithmetic right shift of {A,Q,q_1} after the add/subtract.
          a_d   = {a_sel[WIDTH], a_sel[WIDTH:1]};
          q_d   = {a_sel[0], q_q[WIDTH-1:1]};
          q1_d  = q_q[0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d   = DONE;
            product_d = {a_d[WIDTH-1:0], q_d};
          end
        end
      end
      DONE: begin
        if (abort_in) begin
          // Abort outranks a simultaneous start here.
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          a_d     = '0;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          q_d     = multiplier;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: self-checking bench for booth_mult (WIDTH=8).
// Expected products come from plain signed integer multiplication; expected
// done times come from the start-to-done latency of the block.
module tb_booth_mult;
  import booth_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mc    = '0;
  logic [W-1:0]   mp    = '0;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;
`ifdef BOOTH_ABORT_EN
  logic           abort = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mult #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
`ifdef BOOTH_ABORT_EN
    .abort        (abort),
`endif
    .multiplicand (mc),
    .multiplier   (mp),
    .ready        (ready),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [2*W-1:0] last_prod = '0;
  int             n_checks  = 0;
  int             n_errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  // Every done must match the oldest outstanding multiply, on its due cycle.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        last_prod = exp_q.pop_front();
        check("product", {16'b0, product}, {16'b0, last_prod});
        check("latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; start is seen by exactly the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    mc    = a;
    mp    = b;
    start = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    exp_cyc_q.push_back(cyc + 9);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic flush_expected();
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] ta[8];
  logic [W-1:0] tb[8];
  int           n0;

  initial begin
    ta = '{W'(-3), W'(-128), W'(0),  W'(127), W'(-128), W'(-1), W'(1),    W'(-64)};
    tb = '{W'(5),  W'(-128), W'(-1), W'(127), W'(127),  W'(-1), W'(-128), W'(2)};

    // Reset state.
    idle_cycles(3);
    check("rst_product", {16'b0, product}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_state", {30'b0, state_dbg}, {30'b0, 2'(IDLE)});

    // Release and start together: accepted on the first edge after release.
    reset = 1'b1;
    issue(W'(3), W'(5));
    check("ready_in_run", {31'b0, ready}, 32'd0);
    wait_drain();
    check("product_3x5", {16'b0, product}, 32'h0000_000F);

    // Directed corner operands.
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i]);
      wait_drain();
    end
    idle_cycles(3);
    check("product_held", {16'b0, product}, {16'b0, last_prod});

    // Start during RUN with new operands is ignored.
    issue(W'(7), W'(-9));
    idle_cycles(2);
    mc = W'(55); mp = W'(66); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // Reset mid-RUN: outputs clear at once, no done afterwards.
    issue(W'(100), W'(-77));
    idle_cycles(3);
    reset = 1'b0;
    #1;
    check("midrst_product", {16'b0, product}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_ready", {31'b0, ready}, 32'd1);
    flush_expected();
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(15);
    check("post_rst_ready", {31'b0, ready}, 32'd1);
    issue(W'(-5), W'(-6));
    wait_drain();

    // Start held high: second multiply accepted in DONE, done 9 cycles later.
    n0 = cyc;
    mc = W'(12); mp = W'(-11); start = 1'b1;
    exp_q.push_back(ref_mul(W'(12), W'(-11)));
    exp_cyc_q.push_back(n0 + 9);
    @(posedge clk); #1;
    mc = W'(-100); mp = W'(33);
    exp_q.push_back(ref_mul(W'(-100), W'(33)));
    exp_cyc_q.push_back(n0 + 18);
    while (cyc < n0 + 10) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_drain();

    // Random operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      idle_cycles($urandom_range(0, 3));
      issue(W'($urandom), W'($urandom));
      wait_drain();
    end

`ifdef BOOTH_ABORT_EN
    // Abort sampled at the second RUN edge: back to IDLE, product kept.
    issue(W'(9), W'(9));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_state", {30'b0, state_dbg}, {30'b0, 2'(IDLE)});
    check("abort_product", {16'b0, product}, {16'b0, last_prod});
    flush_expected();
    idle_cycles(15);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    issue(W'(-7), W'(6));
    abort = 1'b0;
    wait_drain();

    // Abort with start in DONE: abort wins, block goes IDLE.
    n0 = cyc;
    issue(W'(21), W'(-3));
    while (cyc < n0 + 9) begin
      @(posedge clk); #1;
    end
    mc = W'(4); mp = W'(4); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_done_state", {30'b0, state_dbg}, {30'b0, 2'(IDLE)});
    idle_cycles(15);
    check("abort_done_product", {16'b0, product}, {16'b0, last_prod});
`endif

    idle_cycles(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply, sampled only while ready=1.
REQ-005 SHALL have port multiplicand  input  WIDTH  signed two's-complement M, captured on accepted start.
REQ-006 SHALL have port multiplier  input  WIDTH  signed two's-complement Q, captured on accepted start.
REQ-007 SHALL have port ready  output  1  high in IDLE and DONE; block can accept start.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking product valid.
REQ-009 SHALL have port product  output  2*WIDTH  signed result, held stable until the next accepted start.
REQ-010 SHALL have port abort  input  1  present only when BOOTH_ABORT_EN is defined (see REQ-027).

Function
REQ-011 SHALL implement radix-2 Booth multiplication with registers A (WIDTH+1 bits), M (WIDTH+1 bits, sign-extended), Q (WIDTH bits), q_1 (1 bit), and iteration counter.
REQ-012 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when counter reaches last iteration; DONE->IDLE after one cycle, or DONE->RUN if start is high in DONE.
REQ-013 On accepted start SHALL load A=0, M={multiplicand[WIDTH-1],multiplicand}, Q=multiplier, q_1=0, counter=WIDTH.
REQ-014 Each RUN cycle SHALL, from {Q[0],q_1}: 01 -> A+M, 10 -> A-M, 00/11 -> A unchanged; then arithmetic-shift {A,Q,q_1} right one bit (A MSB replicated), decrement counter; add and shift in the same cycle.
REQ-015 Add/subtract SHALL be WIDTH+1 bits, two's complement, carry discarded; no overflow is possible given the sign-extended M.
REQ-016 Latency: start sampled at edge t0; RUN occupies edges t1..tWIDTH; done=1 and product valid in the cycle after edge tWIDTH (WIDTH+1 edges after t0).
REQ-017 product SHALL be {A[WIDTH-1:0],Q} registered at the last RUN edge; correct for all operand pairs including -2^(WIDTH-1) x -2^(WIDTH-1).
REQ-018 start while in RUN SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-019 Back-to-back: start high during DONE SHALL be accepted, giving a new done exactly WIDTH+1 cycles later with no IDLE gap.
REQ-020 done SHALL never be high for more than one consecutive cycle per accepted start.

Reset
REQ-021 reset low SHALL asynchronously force state=IDLE, A=0, M=0, Q=0, q_1=0, counter=0, product=0, done=0, ready=1.
REQ-022 reset asserted mid-RUN SHALL discard the operation; no done SHALL follow after release.
REQ-023 Release SHALL be honoured at the next rising edge; start on that edge SHALL be accepted.

Configuration
REQ-024 Macro BOOTH_ABORT_EN SHALL select the abort feature.
REQ-025 Defined: abort input exists; abort high at an edge in RUN SHALL return to IDLE, leave product unchanged, suppress done.
REQ-026 Undefined: no abort port; behaviour exactly per REQ-011..020.
REQ-027 Defined: abort in IDLE/DONE SHALL be ignored; abort and start together in DONE SHALL give abort priority (stay IDLE).

Structure
REQ-028 Package booth_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and counter-width localparam function ($clog2(WIDTH+1)).
REQ-029 SHALL instantiate one sub-module booth_addsub (parametrised width, inputs a, b, sub; output sum) for the A+/-M datapath.
REQ-030 Controller FSM and datapath registers SHALL reside in booth_mult; no other sub-modules.

Verification
REQ-031 WIDTH=8: multiplicand=3, multiplier=5, start one cycle -> done after 9 edges, product=16'h000F.
REQ-032 WIDTH=8: -3 x 5 -> product=16'hFFF1; -128 x -128 -> product=16'h4000; 0 x -1 -> 16'h0000.
REQ-033 start pulsed again 3 cycles into RUN with new operands -> ignored; original product delivered on schedule, single done.
REQ-034 reset pulled low at RUN cycle 4 -> all outputs at reset values immediately, no done after release; next start yields correct result.
REQ-035 start held high continuously, two operand pairs -> done pulses exactly 9 cycles apart, both products correct.
REQ-036 With BOOTH_ABORT_EN: abort at RUN cycle 2 -> IDLE next cycle, ready=1, product retains prior value, no done.
